rf_cpi_sched: RTL and testbench
===============================

Name: rf_cpi_sched

Overview:
- Upstream CPI scheduler for the RF TX timing stage.
- Turns start/stop commands and a latched CPI configuration into the init, stop, pre-CPI and CPI strobes the TX timing stage consumes.
- Counts completed CPIs and monitors that stage's ctrl-over flag to detect CPIs that did not finish.
- Single clock domain, sits between the register/command interface and rf TX timing.

Parameters:
- CNT_W, 24, width of CPI period counter and period/lead config.
- NUM_W, 16, width of CPI count config and completed-CPI counter.
- PRE_LEN, 4, o_pre_cpi high time in cycles; must be >= 4 so the downstream 4-flop edge detector sees it.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- i_start  in  1  one-cycle start command
- i_stop  in  1  one-cycle abort command
- i_cfg_period  in  CNT_W  CPI period in cycles
- i_cfg_lead  in  CNT_W  cycles from pre-CPI rise to CPI pulse
- i_cfg_num  in  NUM_W  CPIs per burst; 0 = continuous until i_stop
- i_ctrl_over_flag  in  1  end-of-TX-window pulse from the TX timing stage
- o_init  out  1  one-cycle pulse, burst starting
- o_stop  out  1  one-cycle pulse, burst ended
- o_pre_cpi  out  1  PRE_LEN-cycle pre-CPI pulse
- o_cpi  out  1  one-cycle CPI pulse
- o_busy  out  1  high from INIT through STOP
- o_cpi_cnt  out  NUM_W  completed CPIs in current or last burst
- o_cfg_err  out  1  sticky; start rejected due to illegal config
- o_miss_err  out  1  sticky; a CPI ended without i_ctrl_over_flag

Behaviour:
- Reset (rst=1 at edge): FSM to IDLE. All outputs 0. All counters 0.
- FSM states: IDLE, INIT, RUN, STOP; WAIT_SYNC only with the optional feature.
- IDLE:
  - i_start with legal config: latch period/lead/num, clear o_cpi_cnt, o_cfg_err and o_miss_err, go to INIT.
  - Legal config means lead >= PRE_LEN, period > lead, period >= 2.
  - i_start with illegal config: set o_cfg_err, stay in IDLE.
- INIT: o_init=1 for exactly this cycle. Period counter pc=0. Go to RUN.
- RUN:
  - pc counts 0..period-1 and wraps to 0.
  - o_pre_cpi=1 while pc < PRE_LEN.
  - o_cpi=1 when pc == lead.
  - An over-seen flag is cleared at pc==0 and set by i_ctrl_over_flag.
  - At pc == period-1:
    - o_cpi_cnt increments; it saturates at all-ones when num=0.
    - If the over-seen flag is 0 (counting a flag arriving this same cycle), set o_miss_err.
    - If num != 0 and the incremented count == num, go to STOP; otherwise pc wraps to 0.
- STOP: o_stop=1 for exactly this cycle. o_busy drops the cycle after. Return to IDLE.
- i_stop in INIT or RUN: go to STOP next cycle. o_pre_cpi and o_cpi are forced low immediately. The partial CPI is not counted.
- i_stop in IDLE: no effect, no o_stop.
- i_start and i_stop in the same cycle: stop wins; from IDLE, nothing happens.
- i_start while busy: ignored; the latched config is unchanged.
- Config inputs are sampled only on accepted i_start; later changes affect the next burst.
- All outputs are registered. Latency from i_start to o_init is 1 cycle. Latency from o_init to first o_pre_cpi rise is 1 cycle.
- Reset mid-burst: outputs 0 on the next edge. No o_stop is emitted.

Optional Feature:
- Macro: RF_CPI_SYNC_EN.
- Defined:
  - Adds input port i_sync (1 bit).
  - INIT and every non-final CPI end go to WAIT_SYNC, not straight to pc=0.
  - WAIT_SYNC holds all strobes low. On i_sync it starts the CPI with pc=0 on the next cycle.
  - i_stop in WAIT_SYNC goes to STOP.
- Undefined: no port. CPIs run back-to-back as described above.

Decomposition:
- Shared package rf_timing_pkg holds:
  - FSM state encoding (IDLE/INIT/RUN/STOP/WAIT_SYNC).
  - Default PRE_LEN=4.
  - TX window length constant 200, which the TX timing stage shares.
- One natural sub-module: rf_cpi_period_cnt.
  - Loadable wrap counter.
  - Outputs pc==0, pc<PRE_LEN, pc==lead and pc==period-1 flags.
  - The top level keeps the FSM, CPI counter and error logic.

Test Plan:
- period=1000, lead=300, num=3, start:
  - o_init 1 cycle after start.
  - o_pre_cpi 4 cycles high at each CPI start.
  - o_cpi exactly 300 cycles after each pre-CPI rise.
  - o_stop 3000 cycles after INIT; o_cpi_cnt=3.
- Same config, i_ctrl_over_flag returned once per CPI except CPI 2 -> o_miss_err set at end of CPI 2 and stays set.
- num=0, period=500, lead=250, i_stop at pc=100 of CPI 5 -> strobes low at once, o_stop next cycle, o_cpi_cnt=4.
- lead=2 (<PRE_LEN) or period=lead -> start rejected, o_cfg_err=1, o_busy=0; a later legal start clears o_cfg_err.
- i_start+i_stop same cycle in IDLE, and i_start during RUN -> no state change, config unchanged.
- rst pulsed mid-RUN -> all outputs 0 next edge, no o_stop.
- With RF_CPI_SYNC_EN: i_sync 50 cycles after each CPI end -> CPI starts 1 cycle after i_sync.

Source files
------------

// File: rtl/rf_timing_pkg.sv
// Shared definitions for the RF timing blocks: scheduler state encoding,
// default pre-CPI length and the TX window length used by the TX timing stage.
package rf_timing_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INIT      = 3'd1,
    ST_RUN       = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_SYNC = 3'd4
  } sched_state_t;

  // o_pre_cpi high time; the downstream 4-flop edge detector needs >= 4.
  localparam int PRE_LEN_DEF = 4;

  // TX window length in cycles, shared with the TX timing stage.
  localparam int TX_WIN_LEN = 200;

endpackage

// File: rtl/rf_cpi_sched_if.sv
// Command/config/strobe bundle between the register interface, the CPI
// scheduler and the TX timing stage. i_sync exists only when RF_CPI_SYNC_EN
// is defined.
interface rf_cpi_sched_if #(
  parameter int CNT_W = 24,
  parameter int NUM_W = 16
);

  logic             i_start;
  logic             i_stop;
  logic [CNT_W-1:0] i_cfg_period;
  logic [CNT_W-1:0] i_cfg_lead;
  logic [NUM_W-1:0] i_cfg_num;
  logic             i_ctrl_over_flag;
`ifdef RF_CPI_SYNC_EN
  logic             i_sync;
`endif
  logic             o_init;
  logic             o_stop;
  logic             o_pre_cpi;
  logic             o_cpi;
  logic             o_busy;
  logic [NUM_W-1:0] o_cpi_cnt;
  logic             o_cfg_err;
  logic             o_miss_err;

  // Command side: issues start/stop and config, consumes strobes and status.
  modport master (
    output i_start, i_stop, i_cfg_period, i_cfg_lead, i_cfg_num, i_ctrl_over_flag,
`ifdef RF_CPI_SYNC_EN
    output i_sync,
`endif
    input  o_init, o_stop, o_pre_cpi, o_cpi, o_busy, o_cpi_cnt, o_cfg_err, o_miss_err
  );

  // Scheduler side.
  modport slave (
    input  i_start, i_stop, i_cfg_period, i_cfg_lead, i_cfg_num, i_ctrl_over_flag,
`ifdef RF_CPI_SYNC_EN
    input  i_sync,
`endif
    output o_init, o_stop, o_pre_cpi, o_cpi, o_busy, o_cpi_cnt, o_cfg_err, o_miss_err
  );

endinterface

// File: rtl/rf_cpi_period_cnt.sv
// Loadable CPI period counter. load starts a CPI at pc=0, step advances pc,
// neither parks the counter with all flags low. The position flags are
// registered alongside pc so they can drive the scheduler outputs directly.
module rf_cpi_period_cnt
  import rf_timing_pkg::*;
#(
  parameter int CNT_W   = 24,
  parameter int PRE_LEN = PRE_LEN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] lead,
  output logic             is_zero,
  output logic             is_pre,
  output logic             is_lead,
  output logic             is_last
);

  logic [CNT_W-1:0] pc;
  logic [CNT_W-1:0] pc_d;
  logic             active_d;

  // Next counter value and whether the counter is running next cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    pc_d     = '0;
    active_d = 1'b0;
    if (load) begin
      pc_d     = '0;
      active_d = 1'b1;
    end else if (step) begin
      pc_d     = pc + CNT_W'(1);
      active_d = 1'b1;
    end
  end

  // Counter register and its registered position flags.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous (sampled on the clock edge); state uses <= so
    // every flop samples pre-edge values regardless of statement order.
    if (rst) begin
      pc      <= '0;
      is_zero <= 1'b0;
      is_pre  <= 1'b0;
      is_lead <= 1'b0;
      is_last <= 1'b0;
    end else begin
      pc      <= pc_d;
      is_zero <= active_d && (pc_d == '0);
      is_pre  <= active_d && (pc_d < CNT_W'(PRE_LEN));
      is_lead <= active_d && (pc_d == lead);
      is_last <= active_d && (pc_d == period - CNT_W'(1));
    end
  end

endmodule

// File: rtl/rf_cpi_sched.sv
// Upstream CPI scheduler for the RF TX timing stage. Converts start/stop
// commands and a latched CPI config into init/stop/pre-CPI/CPI strobes,
// counts completed CPIs and flags CPIs that ended without ctrl-over.
// Optional: define RF_CPI_SYNC_EN to gate every CPI start on i_sync.
module rf_cpi_sched
  import rf_timing_pkg::*;
#(
  parameter int CNT_W   = 24,
  parameter int NUM_W   = 16,
  parameter int PRE_LEN = PRE_LEN_DEF
) (
  input  logic         clk,
  input  logic         rst,
  rf_cpi_sched_if.slave bus
);

  // State entered after INIT and after every non-final CPI.
  localparam sched_state_t CPI_NEXT =
`ifdef RF_CPI_SYNC_EN
    ST_WAIT_SYNC;
`else
    ST_RUN;
`endif

  sched_state_t     state;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] lead_q;
  logic [NUM_W-1:0] num_q;
  logic [NUM_W-1:0] cpi_cnt;
  logic [NUM_W-1:0] cnt_inc;
  logic             init_q;
  logic             stop_q;
  logic             busy_q;
  logic             cfg_err_q;
  logic             miss_err_q;
  logic             seen_q;
  logic             seen_now;
  logic             cfg_legal;
  logic             cpi_end;
  logic             burst_done;
  logic             cnt_load;
  logic             cnt_step;
  logic             pc_zero;
  logic             pc_pre;
  logic             pc_lead;
  logic             pc_last;

  rf_cpi_period_cnt #(
    .CNT_W   (CNT_W),
    .PRE_LEN (PRE_LEN)
  ) u_period_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .step    (cnt_step),
    .period  (period_q),
    .lead    (lead_q),
    .is_zero (pc_zero),
    .is_pre  (pc_pre),
    .is_lead (pc_lead),
    .is_last (pc_last)
  );

  // Config check, CPI-end bookkeeping and period counter control.
  always_comb begin
    cfg_legal  = (bus.i_cfg_lead >= CNT_W'(PRE_LEN)) &&
                 (bus.i_cfg_period > bus.i_cfg_lead) &&
                 (bus.i_cfg_period >= CNT_W'(2));
    // A flag arriving on the last cycle still counts for this CPI.
    seen_now   = (pc_zero ? 1'b0 : seen_q) || bus.i_ctrl_over_flag;
    cpi_end    = (state == ST_RUN) && pc_last && !bus.i_stop;
    cnt_inc    = (&cpi_cnt) ? cpi_cnt : cpi_cnt + NUM_W'(1);
    burst_done = cpi_end && (num_q != '0) && (cnt_inc == num_q);
    cnt_step   = (state == ST_RUN) && !pc_last && !bus.i_stop;
`ifdef RF_CPI_SYNC_EN
    cnt_load   = (state == ST_WAIT_SYNC) && bus.i_sync && !bus.i_stop;
`else
    cnt_load   = ((state == ST_INIT) && !bus.i_stop) || (cpi_end && !burst_done);
`endif
  end

  // Scheduler FSM with registered init/stop/busy strobes, CPI count and errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      period_q   <= '0;
      lead_q     <= '0;
      num_q      <= '0;
      cpi_cnt    <= '0;
      init_q     <= 1'b0;
      stop_q     <= 1'b0;
      busy_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
      miss_err_q <= 1'b0;
      seen_q     <= 1'b0;
    end else begin
      init_q <= 1'b0;
      stop_q <= 1'b0;
      seen_q <= (state == ST_RUN) && seen_now;
      case (state)
        ST_IDLE: begin
          // Stop in the same cycle cancels the start entirely.
          if (bus.i_start && !bus.i_stop) begin
            if (cfg_legal) begin
              period_q   <= bus.i_cfg_period;
              lead_q     <= bus.i_cfg_lead;
              num_q      <= bus.i_cfg_num;
              cpi_cnt    <= '0;
              cfg_err_q  <= 1'b0;
              miss_err_q <= 1'b0;
              init_q     <= 1'b1;
              busy_q     <= 1'b1;
              state      <= ST_INIT;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        ST_INIT: begin
          if (bus.i_stop) begin
            stop_q <= 1'b1;
            state  <= ST_STOP;
          end else begin
            state <= CPI_NEXT;
          end
        end
        ST_RUN: begin
          if (bus.i_stop) begin
            stop_q <= 1'b1;
            state  <= ST_STOP;
          end else if (pc_last) begin
            cpi_cnt <= cnt_inc;
            if (!seen_now) miss_err_q <= 1'b1;
            if (burst_done) begin
              stop_q <= 1'b1;
              state  <= ST_STOP;
            end else begin
              state <= CPI_NEXT;
            end
          end
        end
`ifdef RF_CPI_SYNC_EN
        ST_WAIT_SYNC: begin
          if (bus.i_stop) begin
            stop_q <= 1'b1;
            state  <= ST_STOP;
          end else if (bus.i_sync) begin
            state <= ST_RUN;
          end
        end
`endif
        ST_STOP: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_init     = init_q;
  assign bus.o_stop     = stop_q;
  assign bus.o_pre_cpi  = pc_pre;
  assign bus.o_cpi      = pc_lead;
  assign bus.o_busy     = busy_q;
  assign bus.o_cpi_cnt  = cpi_cnt;
  assign bus.o_cfg_err  = cfg_err_q;
  assign bus.o_miss_err = miss_err_q;

endmodule

// File: tb/tb_rf_cpi_sched.sv
// Self-checking bench for rf_cpi_sched: a behavioural burst model predicts
// every output each cycle, and directed bursts are also checked against
// arithmetic event times (init latency, pre-CPI/CPI spacing, stop time).
module tb_rf_cpi_sched;
  import rf_timing_pkg::*;

  localparam int CNT_W   = 24;
  localparam int NUM_W   = 16;
  localparam int PRE_LEN = PRE_LEN_DEF;
  localparam int CNT_MAX = (1 << NUM_W) - 1;
  localparam int P_INIT  = -1;
  localparam int P_WAIT  = -2;
  localparam int P_END   = -3;
`ifdef RF_CPI_SYNC_EN
  localparam bit SYNC_MODE = 1'b1;
`else
  localparam bit SYNC_MODE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  rf_cpi_sched_if #(.CNT_W(CNT_W), .NUM_W(NUM_W)) bus ();

  rf_cpi_sched #(.CNT_W(CNT_W), .NUM_W(NUM_W), .PRE_LEN(PRE_LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // ---------------- behavioural burst model ----------------
  bit     m_on, m_init, m_stop, m_seen, m_cfg_err, m_miss;
  int     m_pos, m_num, m_cnt;
  longint m_period, m_lead;

  function automatic bit legal(longint p, longint l);
    return (l >= PRE_LEN) && (p > l) && (p >= 2);
  endfunction

  function automatic logic [31:0] model_vec();
    bit pre, cpi;
    pre = m_on && (m_pos >= 0) && (m_pos < PRE_LEN);
    cpi = m_on && (m_pos >= 0) && (m_pos == m_lead);
    return {9'b0, m_init, m_stop, pre, cpi, m_on, m_cfg_err, m_miss, NUM_W'(m_cnt)};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {9'b0, bus.o_init, bus.o_stop, bus.o_pre_cpi, bus.o_cpi, bus.o_busy,
            bus.o_cfg_err, bus.o_miss_err, bus.o_cpi_cnt};
  endfunction

  always @(posedge clk) begin : model
    bit sync_now;
`ifdef RF_CPI_SYNC_EN
    sync_now = bus.i_sync;
`else
    sync_now = 1'b0;
`endif
    m_init = 1'b0;
    m_stop = 1'b0;
    if (rst) begin
      m_on = 0; m_pos = P_END; m_cnt = 0; m_cfg_err = 0; m_miss = 0; m_seen = 0;
    end else if (!m_on) begin
      if (bus.i_start && !bus.i_stop) begin
        if (legal(bus.i_cfg_period, bus.i_cfg_lead)) begin
          m_period = bus.i_cfg_period; m_lead = bus.i_cfg_lead; m_num = bus.i_cfg_num;
          m_cnt = 0; m_cfg_err = 0; m_miss = 0; m_on = 1; m_pos = P_INIT; m_init = 1;
        end else begin
          m_cfg_err = 1;
        end
      end
    end else if (m_pos == P_END) begin
      m_on = 0;
    end else if (bus.i_stop) begin
      m_pos = P_END; m_stop = 1;
    end else if (m_pos == P_INIT) begin
      m_pos = SYNC_MODE ? P_WAIT : 0; m_seen = 0;
    end else if (m_pos == P_WAIT) begin
      if (sync_now) begin m_pos = 0; m_seen = 0; end
    end else begin
      m_seen = m_seen | bus.i_ctrl_over_flag;
      if (m_pos == m_period - 1) begin
        if (m_cnt < CNT_MAX) m_cnt++;
        if (!m_seen) m_miss = 1;
        if (m_num != 0 && m_cnt == m_num) begin
          m_pos = P_END; m_stop = 1;
        end else begin
          m_pos = SYNC_MODE ? P_WAIT : 0; m_seen = 0;
        end
      end else begin
        m_pos++;
      end
    end
  end

  // Whole-output comparison every cycle, away from the active edge.
  always @(negedge clk) check("outputs", dut_vec(), model_vec());

  // ---------------- event recorder ----------------
  int r_init, r_stop, r_miss, r_nstop, r_pre_hi;
  int r_pre[$];
  int r_cpi[$];
  bit prev_pre, prev_miss;

  task automatic clear_rec();
    r_init = -1; r_stop = -1; r_miss = -1; r_nstop = 0; r_pre_hi = 0;
    r_pre.delete(); r_cpi.delete();
  endtask

  always @(posedge clk) begin
    #1;
    if (bus.o_init) r_init = cyc;
    if (bus.o_pre_cpi && !prev_pre) r_pre.push_back(cyc);
    if (bus.o_pre_cpi) r_pre_hi++;
    if (bus.o_cpi) r_cpi.push_back(cyc);
    if (bus.o_stop) begin r_stop = cyc; r_nstop++; end
    if (bus.o_miss_err && !prev_miss) r_miss = cyc;
    prev_pre  = bus.o_pre_cpi;
    prev_miss = bus.o_miss_err;
  end

  // ---------------- ctrl-over flag and sync generators ----------------
  int        flag_mode = 0;  // 0 none, 1 one per CPI per keep mask, 2 random
  bit [31:0] flag_keep;
  int        cpi_idx;

  always @(negedge clk) begin
    if (flag_mode == 1) begin
      bus.i_ctrl_over_flag = bus.o_cpi && (cpi_idx < 32) && flag_keep[cpi_idx];
      if (bus.o_cpi) cpi_idx++;
    end else if (flag_mode == 2) begin
      bus.i_ctrl_over_flag = ($urandom_range(0, 15) == 0);
    end else begin
      bus.i_ctrl_over_flag = 1'b0;
    end
  end

`ifdef RF_CPI_SYNC_EN
  always @(negedge clk) bus.i_sync = ($urandom_range(0, 7) == 0);
`endif

  // ---------------- drive helpers ----------------
  task automatic pulse_start(input int p, input int l, input int n, input bit with_stop,
                             output int t_cmd);
    @(negedge clk);
    bus.i_cfg_period = CNT_W'(p);
    bus.i_cfg_lead   = CNT_W'(l);
    bus.i_cfg_num    = NUM_W'(n);
    bus.i_start      = 1'b1;
    bus.i_stop       = with_stop;
    t_cmd            = cyc;
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_stop  = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (bus.o_busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, bus.o_busy, 1'b0);
  endtask

  initial begin
    int t0, ts;
    bus.i_start = 0; bus.i_stop = 0; bus.i_cfg_period = '0; bus.i_cfg_lead = '0;
    bus.i_cfg_num = '0; bus.i_ctrl_over_flag = 0;
`ifdef RF_CPI_SYNC_EN
    bus.i_sync = 0;
`endif
    clear_rec();
    repeat (3) @(negedge clk);
    check("reset_state", dut_vec(), 32'h0);
    rst = 1'b0;

    // Burst 1: period 1000, lead 300, three CPIs, ctrl-over every CPI.
    clear_rec(); flag_mode = 1; flag_keep = '1; cpi_idx = 0;
    pulse_start(1000, 300, 3, 1'b0, t0);
    wait_idle(5000, "b1_done");
    check("b1_init_lat", r_init, t0 + 1);
    check("b1_cnt", bus.o_cpi_cnt, 3);
    check("b1_miss", bus.o_miss_err, 0);
    check("b1_nstop", r_nstop, 1);
`ifndef RF_CPI_SYNC_EN
    check("b1_pre_rises", r_pre.size(), 3);
    check("b1_cpi_count", r_cpi.size(), 3);
    for (int k = 0; k < r_pre.size(); k++) begin
      check("b1_pre_rise", r_pre[k], r_init + 1 + k * 1000);
      if (k < r_cpi.size()) check("b1_cpi_dist", r_cpi[k] - r_pre[k], 300);
    end
    check("b1_pre_hi", r_pre_hi, 3 * PRE_LEN);
    check("b1_stop_time", r_stop, r_init + 1 + 3 * 1000);
`endif

    // Burst 2: same config, CPI 2 gets no ctrl-over.
    clear_rec(); flag_keep = 32'hFFFF_FFFD; cpi_idx = 0;
    pulse_start(1000, 300, 3, 1'b0, t0);
    wait_idle(5000, "b2_done");
    check("b2_miss", bus.o_miss_err, 1);
    check("b2_cnt", bus.o_cpi_cnt, 3);
`ifndef RF_CPI_SYNC_EN
    check("b2_miss_time", r_miss, r_init + 1 + 2 * 1000);
`endif

    // Burst 3: continuous, abort at pc=100 of CPI 5.
    clear_rec(); flag_keep = '1; cpi_idx = 0;
    pulse_start(500, 250, 0, 1'b0, t0);
`ifndef RF_CPI_SYNC_EN
    while (cyc < r_init + 1 + 4 * 500 + 100) @(negedge clk);
`else
    repeat (2300) @(negedge clk);
`endif
    ts = cyc;
    bus.i_stop = 1'b1;
    @(negedge clk);
    bus.i_stop = 1'b0;
    check("b3_stop_now", {bus.o_stop, bus.o_pre_cpi, bus.o_cpi}, 3'b100);
`ifndef RF_CPI_SYNC_EN
    check("b3_cnt", bus.o_cpi_cnt, 4);
`endif
    wait_idle(10, "b3_done");
    check("b3_stop_time", r_stop, ts + 1);
    check("b3_nstop", r_nstop, 1);

    // Illegal configs, then a legal start clears the error.
    flag_mode = 2;
    pulse_start(1000, 2, 1, 1'b0, t0);
    check("ill_lead", {bus.o_cfg_err, bus.o_busy}, 2'b10);
    pulse_start(300, 300, 1, 1'b0, t0);
    check("ill_period", {bus.o_cfg_err, bus.o_busy}, 2'b10);
    pulse_start(20, 5, 1, 1'b0, t0);
    check("legal_clears", {bus.o_cfg_err, bus.o_init}, 2'b01);
    wait_idle(200, "legal_done");

    // Start and stop together from IDLE: nothing happens.
    clear_rec();
    pulse_start(20, 5, 1, 1'b1, t0);
    check("start_stop_idle", {bus.o_init, bus.o_busy}, 2'b00);
    repeat (3) @(negedge clk);
    check("start_stop_nostop", r_nstop, 0);

    // Start while running is ignored; burst keeps its own config.
    clear_rec(); flag_mode = 0;
    pulse_start(40, 10, 2, 1'b0, t0);
    repeat (15) @(negedge clk);
    pulse_start(8, 4, 0, 1'b0, ts);
    wait_idle(400, "busy_start_done");
    check("busy_start_cnt", bus.o_cpi_cnt, 2);
`ifndef RF_CPI_SYNC_EN
    if (r_pre.size() >= 2) check("busy_start_period", r_pre[1] - r_pre[0], 40);
    else check("busy_start_rises", r_pre.size(), 2);
`endif

    // Reset in the middle of a running burst.
    clear_rec();
    pulse_start(50, 10, 0, 1'b0, t0);
    repeat (70) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid", dut_vec(), 32'h0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_no_stop", r_nstop, 0);

    // Randomised bursts with random aborts, restarts and ctrl-over flags.
    flag_mode = 2;
    for (int it = 0; it < 25; it++) begin
      int p, l, n, len;
      p = $urandom_range(5, 40);
      l = $urandom_range(2, p);
      n = $urandom_range(0, 4);
      pulse_start(p, l, n, 1'b0, t0);
      len = $urandom_range(50, 250);
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        bus.i_stop  = ($urandom_range(0, 99) == 0);
        bus.i_start = ($urandom_range(0, 39) == 0);
        if (bus.i_start) begin
          bus.i_cfg_period = CNT_W'($urandom_range(5, 30));
          bus.i_cfg_lead   = CNT_W'($urandom_range(2, 30));
          bus.i_cfg_num    = NUM_W'($urandom_range(0, 3));
        end
      end
      @(negedge clk);
      bus.i_start = 1'b0;
      bus.i_stop  = 1'b1;
      @(negedge clk);
      bus.i_stop = 1'b0;
      wait_idle(10, "rand_done");
    end

    flag_mode = 0;
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
